// File: rtl/vedic_barrett_mulmod_pkg.sv
// Shared constants for the Barrett modular multiplier and its Vedic multiplier core.
package vedic_barrett_mulmod_pkg;
  localparam int DATA_W  = 64;
  localparam int MU_W    = 31;
  localparam int K_W     = 8;
  localparam int LATENCY = 5;
  localparam int PROD_W  = 2 * DATA_W;
endpackage

// File: rtl/vedic_barrett_mulmod_mul.sv
// Recursive Urdhva-Tiryagbhyam multiplier: 2x2 base cell, four half-width
// partial products merged with adders. Purely combinational, W must be a power of two.
module vedic_mul #(
  parameter int W = 64
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);
  generate
    if (W == 2) begin : g_base
      logic cross_c_s;
      logic high_s;
      assign cross_c_s = (x[1] & y[0]) & (x[0] & y[1]);
      assign high_s    = x[1] & y[1];
      assign p = {high_s & cross_c_s,
                  high_s ^ cross_c_s,
                  (x[1] & y[0]) ^ (x[0] & y[1]),
                  x[0] & y[0]};
    end else begin : g_rec
      localparam int H = W / 2;
      logic [W-1:0]   ll_s;
      logic [W-1:0]   lh_s;
      logic [W-1:0]   hl_s;
      logic [W-1:0]   hh_s;
      logic [W:0]     mid_s;
      logic [2*W-1:0] mid_sh_s;

      vedic_mul #(.W(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll_s));
      vedic_mul #(.W(H)) u_lh (.x(x[H-1:0]), .y(y[W-1:H]), .p(lh_s));
      vedic_mul #(.W(H)) u_hl (.x(x[W-1:H]), .y(y[H-1:0]), .p(hl_s));
      vedic_mul #(.W(H)) u_hh (.x(x[W-1:H]), .y(y[W-1:H]), .p(hh_s));

      // Cross terms carry one extra bit before being aligned to the middle digit.
      assign mid_s    = {1'b0, lh_s} + {1'b0, hl_s};
      assign mid_sh_s = {{(W-1){1'b0}}, mid_s} << H;
      assign p        = {hh_s, ll_s} + mid_sh_s;
    end
  endgenerate
endmodule

// File: rtl/vedic_barrett_mulmod.sv
// Five-stage pipelined modular multiplier t = (a*b) mod q using Barrett
// reduction with a host-supplied mu; every product goes through vedic_mul.
module vedic_barrett_mulmod
  import vedic_barrett_mulmod_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] q,
  input  logic [MU_W-1:0]   mu,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] t
);
  logic [DATA_W-1:0] a_s1_r, b_s1_r, q_s1_r;
  logic [MU_W-1:0]   mu_s1_r;
  logic [K_W-1:0]    k_s1_r;

  logic [PROD_W-1:0] x_s2_r;
  logic [DATA_W-1:0] q_s2_r;
  logic [MU_W-1:0]   mu_s2_r;
  logic [K_W-1:0]    k_s2_r;

  logic [DATA_W-1:0] x_s3_r, q_s3_r, q3_s3_r;
  logic [DATA_W-1:0] r_s4_r, q_s4_r;
  logic [DATA_W-1:0] t_r;

  logic [PROD_W-1:0] ab_prod_s;
  logic [DATA_W-1:0] q1_s;
  logic [PROD_W-1:0] mu_prod_s;
  logic [DATA_W-1:0] q3_s;
  logic [PROD_W-1:0] qq_prod_s;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] corr1_s, corr2_s;

  vedic_mul #(.W(DATA_W)) u_mul_ab (.x(a_s1_r), .y(b_s1_r), .p(ab_prod_s));
  vedic_mul #(.W(DATA_W)) u_mul_mu (.x(q1_s), .y({{(DATA_W-MU_W){1'b0}}, mu_s2_r}), .p(mu_prod_s));
  vedic_mul #(.W(DATA_W)) u_mul_qq (.x(q3_s3_r), .y(q_s3_r), .p(qq_prod_s));

  // Barrett quotient estimate; k-1 and k+1 wrap in K_W bits for illegal k.
  always_comb begin
    q1_s = DATA_W'(x_s2_r >> (k_s2_r - 8'd1));
    q3_s = DATA_W'(mu_prod_s >> (k_s2_r + 8'd1));
  end

  // Remainder estimate; only the low 64 bits of the difference are kept.
  always_comb begin
    r_s = DATA_W'({{DATA_W{1'b0}}, x_s3_r} - qq_prod_s);
  end

  // Up to two conditional subtractions bring r from [0,3q) into [0,q).
  always_comb begin
    corr1_s = r_s4_r;
    corr2_s = r_s4_r;
    if (r_s4_r >= q_s4_r) begin
      corr1_s = r_s4_r - q_s4_r;
    end else begin
      corr1_s = r_s4_r;
    end
    if (corr1_s >= q_s4_r) begin
      corr2_s = corr1_s - q_s4_r;
    end else begin
      corr2_s = corr1_s;
    end
  end

  // Pipeline stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s1_r  <= 64'd0;
      b_s1_r  <= 64'd0;
      q_s1_r  <= 64'd0;
      mu_s1_r <= 31'd0;
      k_s1_r  <= 8'd0;
      x_s2_r  <= 128'd0;
      q_s2_r  <= 64'd0;
      mu_s2_r <= 31'd0;
      k_s2_r  <= 8'd0;
      x_s3_r  <= 64'd0;
      q_s3_r  <= 64'd0;
      q3_s3_r <= 64'd0;
      r_s4_r  <= 64'd0;
      q_s4_r  <= 64'd0;
      t_r     <= 64'd0;
    end else begin
      a_s1_r  <= a;
      b_s1_r  <= b;
      q_s1_r  <= q;
      mu_s1_r <= mu;
      k_s1_r  <= k;
      x_s2_r  <= ab_prod_s;
      q_s2_r  <= q_s1_r;
      mu_s2_r <= mu_s1_r;
      k_s2_r  <= k_s1_r;
      x_s3_r  <= x_s2_r[DATA_W-1:0];
      q_s3_r  <= q_s2_r;
      q3_s3_r <= q3_s;
      r_s4_r  <= r_s;
      q_s4_r  <= q_s3_r;
      t_r     <= corr2_s;
    end
  end

  assign t = t_r;
endmodule

// File: tb/tb_vedic_barrett_mulmod.sv
// Directed and randomized checks of vedic_barrett_mulmod against (a*b) mod q.
module tb_vedic_barrett_mulmod;
  import vedic_barrett_mulmod_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] a, b, q;
  logic [30:0] mu;
  logic [7:0]  k;
  logic [63:0] t;

  int errors = 0;
  int checks = 0;
  logic [63:0] expq[$];

  vedic_barrett_mulmod dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .q(q), .mu(mu), .k(k), .t(t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] qv, input logic [30:0] muv,
                       input logic [7:0] kv);
    a = av; b = bv; q = qv; mu = muv; k = kv;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (t === exp) else begin
      errors++;
      $error("FAIL %s: t=%0d expected %0d", tag, t, exp);
    end
  endtask

  initial begin
    longint unsigned kk, lo, hi, qq, aa, bb, mm;

    rst_n = 1'b0;
    drive(64'd0, 64'd0, 64'd0, 31'd0, 8'd0);
    step(3);
    check("reset", 64'd0);
    rst_n = 1'b1;
    step(2);

    // Vector 1 with latency and hold checks
    drive(64'd146712, 64'd248912, 64'd768112, 31'd1431447, 8'd20);
    step(4);
    check("latency_early", 64'd0);
    step(1);
    check("v1", 64'd28528);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("v1_hold", 64'd28528);
    end

    drive(64'd0, 64'd248912, 64'd768112, 31'd1431447, 8'd20);
    step(5);
    check("v2_zero", 64'd0);

    drive(64'd768111, 64'd768111, 64'd768112, 31'd1431447, 8'd20);
    step(5);
    check("v3_qm1", 64'd1);

    drive(64'd16, 64'd15, 64'd17, 31'd60, 8'd5);
    step(5);
    check("v4_small", 64'd2);
    drive(64'd1, 64'd1, 64'd17, 31'd60, 8'd5);
    step(5);
    check("v4_ones", 64'd1);

    // Back-to-back distinct inputs
    drive(64'd146712, 64'd248912, 64'd768112, 31'd1431447, 8'd20);
    step(1);
    drive(64'd768111, 64'd768111, 64'd768112, 31'd1431447, 8'd20);
    step(1);
    drive(64'd16, 64'd15, 64'd17, 31'd60, 8'd5);
    step(3);
    check("stream_v1", 64'd28528);
    step(1);
    check("stream_v3", 64'd1);
    step(1);
    check("stream_v4", 64'd2);

    // Reset while the pipeline is full
    drive(64'd146712, 64'd248912, 64'd768112, 31'd1431447, 8'd20);
    step(5);
    check("full_before_rst", 64'd28528);
    drive(64'd768111, 64'd768111, 64'd768112, 31'd1431447, 8'd20);
    rst_n = 1'b0;
    step(1);
    check("rst_mid", 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("post_rst_flush", 64'd0);
    end
    step(1);
    check("post_rst_v3", 64'd1);

    // Random legal operands, one new set per cycle
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (expq.size() == LATENCY) check("rand", expq.pop_front());
      kk = longint'($urandom_range(30, 2));
      lo = (64'd1 << (kk - 1)) + ((kk == 30) ? 64'd1 : 64'd0);
      hi = (64'd1 << kk) - 64'd1;
      qq = longint'($urandom_range(32'(hi), 32'(lo)));
      aa = longint'($urandom_range(32'(qq - 1), 0));
      bb = longint'($urandom_range(32'(qq - 1), 0));
      if (n % 17 == 0) begin
        aa = qq - 1;
        bb = qq - 1;
      end
      mm = (64'd1 << (2 * kk)) / qq;
      drive(aa, bb, qq, 31'(mm), 8'(kk));
      expq.push_back((aa * bb) % qq);
    end
    while (expq.size() > 0) begin
      @(negedge clk);
      check("rand_drain", expq.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
